// File: rtl/mdu_hilo.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU, 32-iteration restoring DIV/DIVU,
// MTHI/MTLO writes, with a pipeline stall request and a one-cycle done pulse.
module mdu_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall,
    output logic        done
);

    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic        quot_neg_q;
    logic        rem_neg_q;
    logic        done_q;

    logic        accept_d;
    logic        is_mul_d;
    logic        is_div_d;
    logic        is_signed_div_d;
    logic [63:0] mul_s_d;
    logic [63:0] mul_u_d;
    logic [32:0] partial_d;
    logic [32:0] diff_d;
    logic        qbit_d;
    logic [31:0] rem_next_d;
    logic [31:0] quot_next_d;

    // Operation decode, stall request and one restoring-division step
    always_comb begin
        is_mul_d        = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
        is_div_d        = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
        is_signed_div_d = (alucontrol == EXE_DIV_OP);
        accept_d        = (state_q == IDLE) && start && !flush;
        stall           = (accept_d && (is_mul_d || is_div_d)) ||
                          ((state_q == DIV_RUN) && !flush);

        mul_s_d = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        mul_u_d = {32'd0, a} * {32'd0, b};

        // Shift the next dividend bit into the partial remainder; subtract if it fits
        partial_d   = {rem_q, dvd_q[31]};
        diff_d      = partial_d - {1'b0, dvs_q};
        qbit_d      = !diff_d[32];
        if (qbit_d) begin
            rem_next_d = diff_d[31:0];
        end else begin
            rem_next_d = partial_d[31:0];
        end
        quot_next_d = {dvd_q[30:0], qbit_d};
    end

    // Control FSM together with HI/LO and divider datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            cnt_q      <= 5'd0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        case (alucontrol)
                            EXE_MTHI_OP: hi_q <= a;
                            EXE_MTLO_OP: lo_q <= a;
                            EXE_MULT_OP: begin
                                {hi_q, lo_q} <= mul_s_d;
                                state_q      <= DONE;
                                done_q       <= 1'b1;
                            end
                            EXE_MULTU_OP: begin
                                {hi_q, lo_q} <= mul_u_d;
                                state_q      <= DONE;
                                done_q       <= 1'b1;
                            end
                            EXE_DIV_OP, EXE_DIVU_OP: begin
                                if (b == 32'd0) begin
                                    lo_q    <= 32'hFFFF_FFFF;
                                    hi_q    <= a;
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    dvd_q      <= (is_signed_div_d && a[31]) ? neg32(a) : a;
                                    dvs_q      <= (is_signed_div_d && b[31]) ? neg32(b) : b;
                                    rem_q      <= 32'd0;
                                    cnt_q      <= 5'd0;
                                    quot_neg_q <= is_signed_div_d && (a[31] ^ b[31]);
                                    rem_neg_q  <= is_signed_div_d && a[31];
                                    state_q    <= DIV_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DIV_RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= 5'd0;
                    end else begin
                        rem_q <= rem_next_d;
                        dvd_q <= quot_next_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            lo_q    <= quot_neg_q ? neg32(quot_next_d) : quot_next_d;
                            hi_q    <= rem_neg_q ? neg32(rem_next_d) : rem_next_d;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: cycle-level reference model compared every cycle, plus
// directed vectors with hand-computed HI/LO/stall expectations.
module tb_mdu_hilo;

    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_r = 1'b0;
    logic [7:0]  op_r = 8'd0;
    logic [31:0] a_r = 32'd0;
    logic [31:0] b_r = 32'd0;
    logic        flush_r = 1'b0;
    logic [31:0] hi_s, lo_s;
    logic        stall_s, done_s;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mdu_hilo dut (
        .clk(clk), .rst(rst), .start(start_r), .alucontrol(op_r),
        .a(a_r), .b(b_r), .flush(flush_r),
        .hi_o(hi_s), .lo_o(lo_s), .stall(stall_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = free, 1 = dividing, 2 = result just committed
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, pend_hi, pend_lo;
    int m_mode = 0;
    int m_left = 0;

    function automatic bit is_long_op(input logic [7:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    always @(posedge clk) begin
        int sa, sb;
        longint ps;
        longint unsigned pu;
        sa = a_r;
        sb = b_r;
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (start_r && !flush_r) begin
                if (op_r == OP_MTHI) m_hi = a_r;
                else if (op_r == OP_MTLO) m_lo = a_r;
                else if (op_r == OP_MULT) begin
                    ps = longint'(sa) * longint'(sb);
                    {m_hi, m_lo} = ps;
                    m_mode = 2;
                end else if (op_r == OP_MULTU) begin
                    pu = {32'd0, a_r} * {32'd0, b_r};
                    {m_hi, m_lo} = pu;
                    m_mode = 2;
                end else if (op_r == OP_DIV || op_r == OP_DIVU) begin
                    if (b_r == 32'd0) begin
                        m_lo = 32'hFFFF_FFFF; m_hi = a_r; m_mode = 2;
                    end else begin
                        if (op_r == OP_DIVU) begin
                            pend_lo = a_r / b_r; pend_hi = a_r % b_r;
                        end else if (a_r == 32'h8000_0000 && b_r == 32'hFFFF_FFFF) begin
                            pend_lo = 32'h8000_0000; pend_hi = 32'd0;
                        end else begin
                            pend_lo = sa / sb; pend_hi = sa % sb;
                        end
                        m_left = 32; m_mode = 1;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (flush_r) m_mode = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = pend_hi; m_lo = pend_lo; m_mode = 2;
                end
            end
        end else begin
            m_mode = 0;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", hi_s, m_hi);
            check("lo", lo_s, m_lo);
            check("stall", {31'd0, stall_s},
                  {31'd0, (m_mode == 0 && start_r && !flush_r && is_long_op(op_r)) ||
                          (m_mode == 1 && !flush_r)});
            check("done", {31'd0, done_s}, {31'd0, m_mode == 2});
        end
    end

    // Drive one instruction; hold it in EX until done (or for one cycle if single-cycle)
    task automatic run_op(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output int nstall);
        bit got;
        nstall = 0;
        got = 1'b0;
        @(posedge clk); #1;
        start_r = 1'b1; op_r = op; a_r = av; b_r = bv;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_s) nstall++;
            if (done_s) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_start();
        @(posedge clk); #1;
        start_r = 1'b0; op_r = 8'd0;
    endtask

    task automatic single_op(input logic [7:0] op, input logic [31:0] av);
        @(posedge clk); #1;
        start_r = 1'b1; op_r = op; a_r = av;
        @(posedge clk); #1;
        start_r = 1'b0; op_r = 8'd0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_hi", hi_s, 32'd0);
        check("reset_lo", lo_s, 32'd0);
        check("reset_stall", {31'd0, stall_s}, 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_stalls", n, 32'd1);
        check("mult_hi", hi_s, 32'hFFFF_FFFF);
        check("mult_lo", lo_s, 32'hFFFF_FFFA);
        release_start();

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_hi", hi_s, 32'h0000_0001);
        check("multu_lo", lo_s, 32'hFFFF_FFFE);
        release_start();

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        check("div_stalls", n, 32'd33);
        check("div_lo", lo_s, 32'hFFFF_FFFD);
        check("div_hi", hi_s, 32'hFFFF_FFFF);
        release_start();
        @(negedge clk);
        check("div_done_once", {31'd0, done_s}, 32'd0);

        run_op(OP_DIVU, 32'd100, 32'd0, n);
        check("div0_stalls", n, 32'd1);
        check("div0_lo", lo_s, 32'hFFFF_FFFF);
        check("div0_hi", hi_s, 32'd100);
        release_start();

        run_op(OP_DIVU, 32'd1000, 32'd7, n);
        check("divu_lo", lo_s, 32'd142);
        check("divu_hi", hi_s, 32'd6);
        release_start();

        single_op(OP_MTHI, 32'hCAFE_0001);
        single_op(8'h00, 32'h5555_5555);
        @(negedge clk);
        check("mthi_hi", hi_s, 32'hCAFE_0001);
        check("ignored_lo", lo_s, 32'd142);

        // Flush in IDLE blocks a multiply
        @(posedge clk); #1;
        start_r = 1'b1; op_r = OP_MULT; a_r = 32'd5; b_r = 32'd5; flush_r = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {31'd0, stall_s}, 32'd0);
        @(posedge clk); #1;
        start_r = 1'b0; flush_r = 1'b0;
        @(negedge clk);
        check("flush_idle_lo", lo_s, 32'd142);

        // DIVU 10/3 flushed at iteration 12
        @(posedge clk); #1;
        start_r = 1'b1; op_r = OP_DIVU; a_r = 32'd10; b_r = 32'd3;
        @(negedge clk);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        flush_r = 1'b1; start_r = 1'b0;
        @(negedge clk);
        check("flush_run_stall", {31'd0, stall_s}, 32'd0);
        @(posedge clk); #1;
        flush_r = 1'b0;
        @(negedge clk);
        check("flush_run_done", {31'd0, done_s}, 32'd0);
        check("flush_run_hi", hi_s, 32'hCAFE_0001);
        check("flush_run_lo", lo_s, 32'd142);
        single_op(OP_MTLO, 32'h0000_1234);
        @(negedge clk);
        check("mtlo_lo", lo_s, 32'h0000_1234);

        // Reset mid-division
        @(posedge clk); #1;
        start_r = 1'b1; op_r = OP_DIV; a_r = 32'd77; b_r = 32'd5;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1; start_r = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_run_hi", hi_s, 32'd0);
        check("rst_run_lo", lo_s, 32'd0);
        check("rst_run_stall", {31'd0, stall_s}, 32'd0);
        check("rst_run_done", {31'd0, done_s}, 32'd0);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("ovf_lo", lo_s, 32'h8000_0000);
        check("ovf_hi", hi_s, 32'd0);
        release_start();

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
        check("div_pos_neg_lo", lo_s, 32'hFFFF_FFFD);
        check("div_pos_neg_hi", hi_s, 32'd1);
        release_start();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  EX-stage instruction valid for this unit.
REQ-004 alucontrol  input  8  operation code from the ALU decoder; `defines.vh` _OP encodings.
REQ-005 a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-006 b  input  32  rt operand (divisor / multiplier).
REQ-007 flush  input  1  pipeline flush from exception logic; cancels in-flight op.
REQ-008 hi_o  output  32  current HI register (MFHI source).
REQ-009 lo_o  output  32  current LO register (MFLO source).
REQ-010 stall  output  1  freeze request to pipeline; combinational.
REQ-011 done  output  1  result-committed indicator, high exactly one cycle per completed MULT/MULTU/DIV/DIVU.
REQ-012 Clock and reset: one clock; reset is synchronous and active-high.

Function
REQ-013 Recognised ops: EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_MTHI_OP, EXE_MTLO_OP; any other code with start=1 is ignored (no state change, stall=0).
REQ-014 FSM states: IDLE, DIV_RUN, DONE; ops accepted only in IDLE with start=1 and flush=0.
REQ-015 MTHI/MTLO in IDLE: HI (resp. LO) <= a at the edge; other register unchanged; stall=0; state stays IDLE; done=0.
REQ-016 MULT/MULTU accept: stall=1 in accept cycle; {HI,LO} <= 64-bit signed (MULT) / unsigned (MULTU) product at accept edge; next state DONE.
REQ-017 DIV/DIVU with b!=0: stall=1 in accept cycle; latch operand magnitudes and signs; next state DIV_RUN with iteration counter 0.
REQ-018 DIV_RUN: radix-2 restoring, one quotient bit per cycle, counter 0..31; stall=1 every DIV_RUN cycle; on edge ending iteration 31 write LO=quotient, HI=remainder, go to DONE.
REQ-019 Division total stall = 33 cycles (accept + 32); multiply total stall = 1 cycle.
REQ-020 Signed division: quotient negated when operand signs differ; remainder takes dividend sign; 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
REQ-021 Divide by zero (DIV or DIVU, b=0): no DIV_RUN; at accept edge LO<=0xFFFFFFFF, HI<=a; next state DONE; stall=1 in accept cycle only.
REQ-022 DONE: stall=0, done=1, start ignored (same instruction still in EX); next state IDLE unconditionally.
REQ-023 stall = (IDLE & start & !flush & op in {MULT,MULTU,DIV,DIVU}) | (state==DIV_RUN & !flush).
REQ-024 flush in DIV_RUN: abort, HI/LO unchanged, next state IDLE, done not asserted; flush in IDLE blocks acceptance; flush in DONE: no effect (result already committed).
REQ-025 hi_o/lo_o driven directly from registers; a value written at edge N is visible from cycle N+1.

Reset
REQ-026 rst=1 at an edge: HI=0, LO=0, state IDLE, counter 0; stall=0 and done=0 while in IDLE; rst overrides flush and start.
REQ-027 rst during DIV_RUN aborts the division with HI=LO=0; no done pulse.

Verification
REQ-028 MULT a=0xFFFFFFFE (-2), b=3 -> stall 1 cycle, next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1.
REQ-029 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> stall exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, done one cycle.
REQ-031 DIVU a=100, b=0 -> stall 1 cycle, LO=0xFFFFFFFF, HI=100.
REQ-032 DIVU a=10, b=3 with flush at iteration 12 -> stall drops that cycle, HI/LO retain prior values, no done; following MTLO a=0x1234 -> LO=0x1234 next cycle.
REQ-033 rst asserted mid-DIV_RUN -> next cycle HI=LO=0, stall=0, done=0; DIV 0x80000000 / 0xFFFFFFFF afterwards -> LO=0x80000000, HI=0.
